// File: rtl/aes_round_key_sequencer.sv
// Sequences AES key expansion and streams the latched round-key schedule (round 0..NO_ROUNDS)
// to an iterative round engine, one key per accepted handshake.
module aes_round_key_sequencer #(
    parameter int DATA_W    = 128,
    parameter int KEY_LEN   = 128,
    parameter int NO_ROUNDS = 10,
    parameter int TIMEOUT   = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          key_valid,
    output logic                          key_ready,
    input  logic [KEY_LEN-1:0]            cipher_key,
    output logic                          kexp_valid_in,
    output logic [KEY_LEN-1:0]            kexp_cipher_key,
    input  logic [NO_ROUNDS*DATA_W-1:0]   kexp_superkey,
    input  logic [NO_ROUNDS-1:0]          kexp_valid_out,
    input  logic                          blk_start,
    output logic                          blk_ready,
    output logic                          rk_valid,
    input  logic                          rk_ready,
    output logic [3:0]                    rk_round,
    output logic [DATA_W-1:0]             rk_key,
    output logic                          rk_last,
    output logic                          key_loaded,
    output logic                          kexp_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2,
        ISSUE  = 2'd3
    } state_t;

    state_t                        state_r, state_s;
    logic [CNT_W-1:0]              cnt_r, cnt_s;
    logic [KEY_LEN-1:0]            key_r, key_s;
    logic [NO_ROUNDS*DATA_W-1:0]   sched_r, sched_s;
    logic                          kvi_r, kvi_s;
    logic                          key_loaded_r, key_loaded_s;
    logic                          kexp_err_r, kexp_err_s;
    logic                          rk_valid_r, rk_valid_s;
    logic [3:0]                    rk_round_r, rk_round_s;
    logic [DATA_W-1:0]             rk_key_r, rk_key_s;
    logic                          rk_last_r, rk_last_s;
    logic                          key_ready_r, key_ready_s;
    logic                          blk_en_r, blk_en_s;
    logic                          key_acc_s;
    logic                          blk_acc_s;

    // Round 0 is the cipher key itself; round k sits in the superkey with round 1 most significant.
    function automatic logic [DATA_W-1:0] round_key(
        input logic [3:0]                  idx,
        input logic [KEY_LEN-1:0]          key,
        input logic [NO_ROUNDS*DATA_W-1:0] sched
    );
        logic [DATA_W-1:0] rk;
        rk = key;
        for (int k = 1; k <= NO_ROUNDS; k++) begin
            if (idx == 4'(k)) begin
                rk = sched[(NO_ROUNDS-k)*DATA_W +: DATA_W];
            end else begin
                rk = rk;
            end
        end
        return rk;
    endfunction

    // A new key wins over a block request offered in the same cycle.
    assign key_acc_s = key_valid & key_ready_r;
    assign blk_ready = blk_en_r & ~key_valid;
    assign blk_acc_s = blk_start & blk_ready;

    // Next-state and next-register values.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        key_s        = key_r;
        sched_s      = sched_r;
        kvi_s        = 1'b0;
        key_loaded_s = key_loaded_r;
        kexp_err_s   = kexp_err_r;
        rk_valid_s   = rk_valid_r;
        rk_round_s   = rk_round_r;
        rk_key_s     = rk_key_r;
        rk_last_s    = rk_last_r;

        case (state_r)
            IDLE, READY: begin
                if (key_acc_s) begin
                    key_s        = cipher_key;
                    kexp_err_s   = 1'b0;
                    key_loaded_s = 1'b0;
                    cnt_s        = '0;
                    kvi_s        = 1'b1;
                    state_s      = EXPAND;
                end else if (blk_acc_s && (state_r == READY)) begin
                    rk_valid_s = 1'b1;
                    rk_round_s = 4'd0;
                    rk_key_s   = round_key(4'd0, key_r, sched_r);
                    rk_last_s  = 1'b0;
                    state_s    = ISSUE;
                end else begin
                    state_s = state_r;
                end
            end
            EXPAND: begin
                if (kexp_valid_out[NO_ROUNDS-1]) begin
                    sched_s      = kexp_superkey;
                    key_loaded_s = 1'b1;
                    state_s      = READY;
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    kexp_err_s   = 1'b1;
                    key_loaded_s = 1'b0;
                    state_s      = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ISSUE: begin
                if (rk_ready) begin
                    if (rk_round_r == 4'(NO_ROUNDS)) begin
                        rk_valid_s = 1'b0;
                        rk_round_s = 4'd0;
                        rk_key_s   = '0;
                        rk_last_s  = 1'b0;
                        state_s    = READY;
                    end else begin
                        rk_round_s = rk_round_r + 4'd1;
                        rk_key_s   = round_key(rk_round_r + 4'd1, key_r, sched_r);
                        rk_last_s  = ((rk_round_r + 4'd1) == 4'(NO_ROUNDS));
                    end
                end else begin
                    rk_valid_s = rk_valid_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        key_ready_s = (state_s == IDLE) || (state_s == READY);
        blk_en_s    = (state_s == READY);
    end

    // State and output registers; reset drops any schedule and stream immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            key_r        <= '0;
            sched_r      <= '0;
            kvi_r        <= 1'b0;
            key_loaded_r <= 1'b0;
            kexp_err_r   <= 1'b0;
            rk_valid_r   <= 1'b0;
            rk_round_r   <= 4'd0;
            rk_key_r     <= '0;
            rk_last_r    <= 1'b0;
            key_ready_r  <= 1'b0;
            blk_en_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            key_r        <= key_s;
            sched_r      <= sched_s;
            kvi_r        <= kvi_s;
            key_loaded_r <= key_loaded_s;
            kexp_err_r   <= kexp_err_s;
            rk_valid_r   <= rk_valid_s;
            rk_round_r   <= rk_round_s;
            rk_key_r     <= rk_key_s;
            rk_last_r    <= rk_last_s;
            key_ready_r  <= key_ready_s;
            blk_en_r     <= blk_en_s;
        end
    end

    assign key_ready       = key_ready_r;
    assign kexp_valid_in   = kvi_r;
    assign kexp_cipher_key = key_r;
    assign rk_valid        = rk_valid_r;
    assign rk_round        = rk_round_r;
    assign rk_key          = rk_key_r;
    assign rk_last         = rk_last_r;
    assign key_loaded      = key_loaded_r;
    assign kexp_err        = kexp_err_r;

endmodule

// File: tb/tb_aes_round_key_sequencer.sv
// Scoreboard bench for aes_round_key_sequencer with a behavioural key-expansion core model.
module tb_aes_round_key_sequencer;

    localparam int DW  = 128;
    localparam int NR  = 10;
    localparam int TMO = 64;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 key_valid;
    logic                 key_ready;
    logic [DW-1:0]        cipher_key;
    logic                 kexp_valid_in;
    logic [DW-1:0]        kexp_cipher_key;
    logic [NR*DW-1:0]     kexp_superkey;
    logic [NR-1:0]        kexp_valid_out;
    logic                 blk_start;
    logic                 blk_ready;
    logic                 rk_valid;
    logic                 rk_ready;
    logic [3:0]           rk_round;
    logic [DW-1:0]        rk_key;
    logic                 rk_last;
    logic                 key_loaded;
    logic                 kexp_err;

    int total = 0;
    int bad   = 0;
    int kv_cnt = 0;
    bit stall_mode = 1'b0;
    bit hold_off   = 1'b0;

    logic [DW-1:0] q_key[$];
    int            q_rnd[$];
    logic [DW-1:0] fips_tab [1:NR];

    localparam logic [DW-1:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [DW-1:0] K2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [DW-1:0] K3 = 128'h0f0e0d0c0b0a09080706050403020100;

    always #5 clk = ~clk;

    aes_round_key_sequencer #(.DATA_W(DW), .KEY_LEN(DW), .NO_ROUNDS(NR), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_ready(key_ready),
        .cipher_key(cipher_key), .kexp_valid_in(kexp_valid_in), .kexp_cipher_key(kexp_cipher_key),
        .kexp_superkey(kexp_superkey), .kexp_valid_out(kexp_valid_out), .blk_start(blk_start),
        .blk_ready(blk_ready), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_round(rk_round),
        .rk_key(rk_key), .rk_last(rk_last), .key_loaded(key_loaded), .kexp_err(kexp_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // FIPS-197 schedule for K1; any other key gets an arbitrary but deterministic schedule.
    function automatic logic [DW-1:0] exp_rk(input logic [DW-1:0] key, input int k);
        logic [31:0] w;
        if (k == 0) return key;
        if (key == K1) return fips_tab[k];
        w = 32'(k) * 32'h9e3779b9;
        return key ^ {w, w, w, w};
    endfunction

    function automatic logic [NR*DW-1:0] sk_model(input logic [DW-1:0] key);
        logic [NR*DW-1:0] sk;
        sk = '0;
        for (int k = 1; k <= NR; k++) sk[(NR-k)*DW +: DW] = exp_rk(key, k);
        return sk;
    endfunction

    // Expansion core model: a few cycles after the start pulse, raise non-final valids, then done.
    initial begin
        logic [DW-1:0] k;
        kexp_valid_out = '0;
        kexp_superkey  = '0;
        forever begin
            @(posedge clk); #1;
            if (kexp_valid_in && !hold_off) begin
                k = kexp_cipher_key;
                @(posedge clk); #1;
                kexp_valid_out = {1'b0, {(NR-1){1'b1}}};
                repeat (2) @(posedge clk);
                #1;
                kexp_superkey  = sk_model(k);
                kexp_valid_out = '1;
                @(posedge clk); #1;
                kexp_valid_out = '0;
            end
        end
    end

    // Consumer back-pressure.
    initial begin
        rk_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            rk_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard monitor: every valid cycle must match the queue head, popped on transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (kexp_valid_in) kv_cnt++;
            if (rk_valid) begin
                if (q_key.size() == 0) begin
                    chk("rk_valid_unexpected", 128'(rk_valid), 128'(0));
                end else begin
                    chk("rk_round", 128'(rk_round), 128'(q_rnd[0]));
                    chk("rk_key", rk_key, q_key[0]);
                    chk("rk_last", 128'(rk_last), 128'(q_rnd[0] == NR));
                    if (rk_ready) begin
                        void'(q_key.pop_front());
                        void'(q_rnd.pop_front());
                    end
                end
            end else begin
                chk("rk_idle_zero", {rk_last, rk_key[126:0]}, 128'(0));
            end
        end
    end

    task automatic load_key(input logic [DW-1:0] k);
        int n = 0;
        @(negedge clk);
        while (!key_ready && n < 100) begin @(negedge clk); n++; end
        chk("key_ready", 128'(key_ready), 128'(1));
        kv_cnt     = 0;
        cipher_key = k;
        key_valid  = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        chk("kexp_valid_in", 128'(kexp_valid_in), 128'(1));
        chk("kexp_cipher_key", kexp_cipher_key, k);
        chk("err_cleared", 128'(kexp_err), 128'(0));
        chk("loaded_cleared", 128'(key_loaded), 128'(0));
    endtask

    task automatic wait_loaded();
        int n = 0;
        while (!key_loaded && n < 200) begin @(negedge clk); n++; end
        chk("key_loaded", 128'(key_loaded), 128'(1));
        chk("kvi_pulses", 128'(kv_cnt), 128'(1));
        chk("no_err", 128'(kexp_err), 128'(0));
    endtask

    task automatic run_block(input logic [DW-1:0] k, input bit check_lat);
        int n = 0;
        @(negedge clk);
        while (!blk_ready && n < 100) begin @(negedge clk); n++; end
        chk("blk_ready", 128'(blk_ready), 128'(1));
        for (int r = 0; r <= NR; r++) begin
            q_key.push_back(exp_rk(k, r));
            q_rnd.push_back(r);
        end
        blk_start = 1'b1;
        @(negedge clk);
        blk_start = 1'b0;
        chk("rk_valid_first", 128'(rk_valid), 128'(1));
        if (check_lat) begin
            repeat (NR) @(negedge clk);
            #2;
            chk("block_latency", 128'(q_key.size()), 128'(0));
        end
        n = 0;
        while (q_key.size() != 0 && n < 400) begin @(negedge clk); n++; end
        chk("drained", 128'(q_key.size()), 128'(0));
        @(negedge clk);
        chk("rk_valid_end", 128'(rk_valid), 128'(0));
        chk("back_ready", 128'(blk_ready), 128'(1));
    endtask

    initial begin
        int n;
        fips_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        reset      = 1'b0;
        key_valid  = 1'b0;
        cipher_key = '0;
        blk_start  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {key_ready, blk_ready, rk_valid, kexp_valid_in, key_loaded, kexp_err, rk_last},
            128'(0));
        chk("rst_rk_key", rk_key, 128'(0));
        reset = 1'b1;

        // FIPS-197 key, straight stream then stalled stream
        load_key(K1);
        wait_loaded();
        run_block(K1, 1'b1);
        stall_mode = 1'b1;
        run_block(K1, 1'b0);
        stall_mode = 1'b0;

        // key load and block request collide in READY
        @(negedge clk);
        kv_cnt     = 0;
        cipher_key = K2;
        key_valid  = 1'b1;
        blk_start  = 1'b1;
        #1;
        chk("collide_blk_ready", 128'(blk_ready), 128'(0));
        chk("collide_key_ready", 128'(key_ready), 128'(1));
        @(negedge clk);
        key_valid = 1'b0;
        blk_start = 1'b0;
        chk("collide_kvi", 128'(kexp_valid_in), 128'(1));
        chk("collide_no_rk", 128'(rk_valid), 128'(0));
        wait_loaded();
        run_block(K2, 1'b1);

        // expansion timeout
        hold_off = 1'b1;
        load_key(K3);
        n = 1;
        while (!kexp_err && n < 300) begin @(negedge clk); n++; end
        chk("tmo_err", 128'(kexp_err), 128'(1));
        chk("tmo_not_early", 128'(n >= TMO), 128'(1));
        chk("tmo_not_late", 128'(n <= TMO + 2), 128'(1));
        chk("tmo_idle_key_ready", 128'(key_ready), 128'(1));
        chk("tmo_blk_ready", 128'(blk_ready), 128'(0));
        chk("tmo_loaded", 128'(key_loaded), 128'(0));
        hold_off = 1'b0;
        load_key(K1);
        wait_loaded();

        // reset in the middle of a stream
        for (int r = 0; r <= NR; r++) begin
            q_key.push_back(exp_rk(K1, r));
            q_rnd.push_back(r);
        end
        @(negedge clk);
        blk_start = 1'b1;
        @(negedge clk);
        blk_start = 1'b0;
        n = 0;
        while (!(rk_valid && rk_round == 4'd5) && n < 100) begin @(negedge clk); n++; end
        chk("reached_r5", 128'(rk_round), 128'(5));
        reset = 1'b0;
        #1;
        q_key.delete();
        q_rnd.delete();
        chk("midrst_outputs", {key_ready, blk_ready, rk_valid, kexp_valid_in, key_loaded, kexp_err, rk_last},
            128'(0));
        chk("midrst_rk_round", 128'(rk_round), 128'(0));
        chk("midrst_rk_key", rk_key, 128'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_loaded", 128'(key_loaded), 128'(0));
        chk("post_rst_key_ready", 128'(key_ready), 128'(1));
        chk("post_rst_blk_ready", 128'(blk_ready), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
